nfu_tile_sequencer: RTL and testbench
=====================================

Name: nfu_tile_sequencer

Overview:
- Control FSM for the NFU pipeline (NBin/SB registers, NFU-1, NFU-2 accumulator, NFU-3, NBout).
- Sequences one output tile: issues K back-to-back NBin/SB reads, seeds the NFU-2 accumulator from NBout, then selects a partial (NFU-2) or final (NFU-3) result and writes it to NBout.
- Also streams sigmoid coefficients into the NFU-3 RAM.
- Sits between the layer-level scheduler and the pipeline control inputs.

Parameters:
- CNT_W, 10, width of the block count and tile cycle counter.
- LOAD_OFS, 7, cycles from the first issue to the o_load_nbout pulse; must be ≥1.
- WR_OFS_NFU2, 10, cycles from the last issue to the NBout write for a partial result.
- WR_OFS_NFU3, 13, cycles from the last issue to the NBout write for a final result.
- SIG_ENTRIES, 16, number of sigmoid coefficient words per configuration.
- COEF_W, 32, coefficient width (2*BIT_WIDTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_start  in  1  tile start request; sampled only in IDLE.
- i_num_blocks  in  CNT_W  K, the number of input blocks to accumulate; sampled with i_start.
- i_final  in  1  1 = write the NFU-3 result, 0 = write the NFU-2 partial sum; sampled with i_start.
- i_buf_ready  in  1  NBin/SB hold all K blocks; required together with i_start.
- i_coef_start  in  1  begin a sigmoid coefficient load.
- i_coef_valid  in  1  coefficient beat valid.
- i_coef_data  in  COEF_W  coefficient word.
- o_coef_ready  out  1  ready for a coefficient beat.
- o_sigmoid_coef  out  COEF_W  coefficient to NFU-3.
- o_load_sigmoid_coef  out  1  NFU-3 coefficient write strobe.
- o_rd_en  out  1  NBin/SB read strobe.
- o_rd_idx  out  CNT_W  block index for the current read.
- o_nbout_rd_en  out  1  read the partial sum from NBout.
- o_load_nbout  out  1  drives the pipeline i_load_nbout.
- o_nbout_nfu2_nfu3  out  1  drives the pipeline i_nbout_nfu2_nfu3 (1 = NFU-2 result).
- o_nbout_wr_en  out  1  NBout write strobe.
- o_busy  out  1  high when not IDLE.
- o_done  out  1  one-cycle tile-complete pulse.
- o_err  out  1  one-cycle pulse on an illegal start.

Behaviour:
- Reset (async on rst_n low): state IDLE, all counters 0; every output 0 except o_nbout_nfu2_nfu3 = 1.
- States: IDLE, COEF, RUN, DONE.
- IDLE:
  - i_coef_start → COEF. It has priority over i_start in the same cycle; i_start is then dropped.
  - i_start & i_buf_ready & K≠0 → RUN. Latch K and i_final; counter t = 0.
  - i_start & K==0 → o_err pulse next cycle; stay IDLE.
  - i_start & !i_buf_ready → ignored; no error.
- COEF:
  - o_coef_ready = 1.
  - Each cycle with i_coef_valid: o_load_sigmoid_coef = 1 and o_sigmoid_coef = i_coef_data, both combinational pass-through. Coefficient count increments.
  - After SIG_ENTRIES beats → IDLE. o_coef_ready drops the cycle after the last beat.
- RUN (t increments every cycle, starting at 0):
  - o_rd_en = 1 and o_rd_idx = t while t < K. Issues are strictly back-to-back because the pipeline cannot stall.
  - o_nbout_rd_en = 1 at t == LOAD_OFS-1.
  - o_load_nbout = 1 at t == LOAD_OFS.
  - o_nbout_nfu2_nfu3 = !i_final (latched) for the whole of RUN.
  - o_nbout_wr_en = 1 for exactly one cycle at t == K-1+WR, where WR = WR_OFS_NFU3 if i_final, else WR_OFS_NFU2. Then → DONE.
  - These events are independent and may coincide or occur after issuing ends (small K). Each fires exactly once per tile.
- DONE: o_done = 1 for one cycle → IDLE. A new start is accepted the following cycle.
- Starts and coefficient starts during COEF/RUN/DONE are ignored.
- Arithmetic: t is CNT_W bits. Configurations where K-1+max(WR, LOAD_OFS) ≥ 2^CNT_W are unsupported.
- Reset mid-operation aborts immediately. No write is issued, and the partial coefficient count is discarded.
- All strobe outputs are registered except the coefficient pass-through.

Decomposition:
- Shared package nfu_ctrl_pkg:
  - state encoding (IDLE=0, COEF=1, RUN=2, DONE=3);
  - default offset constants LOAD_OFS/WR_OFS_NFU2/WR_OFS_NFU3, derived from the pipeline stage counts (NBin reg 1, NFU-1 3, pipe reg 1, NFU-2 2, NFU-3 3).
- One natural sub-module: nfu_tile_timer. It holds the t counter and the event comparators (issue window, nbout read/load, write) and is reused by a future multi-tile scheduler.

Test Plan:
- Reset, then i_start with K=4, i_final=0, i_buf_ready=1:
  - o_rd_en high at t=0..3 with o_rd_idx 0,1,2,3;
  - o_nbout_rd_en at t=6, o_load_nbout at t=7;
  - o_nbout_wr_en at t=13 with o_nbout_nfu2_nfu3=1;
  - o_done one cycle later.
- K=1, i_final=1 → o_rd_en only at t=0; o_load_nbout at t=7; o_nbout_wr_en at t=13 with o_nbout_nfu2_nfu3=0.
- K=0 → o_err pulse; o_busy stays 0; no o_rd_en.
- i_coef_start then 16 beats with i_coef_valid toggling 1,0,1,… → exactly 16 o_load_sigmoid_coef pulses with data matching the inputs; returns to IDLE; an i_start asserted during COEF is ignored.
- i_start and i_coef_start in the same IDLE cycle → COEF entered; no reads issued.
- rst_n low at t=5 of a K=20 tile → all outputs return to reset values asynchronously; no o_nbout_wr_en or o_done; a new tile starts cleanly after release.

Source files
------------

// File: rtl/nfu_ctrl_pkg.sv
// Shared control definitions for the NFU pipeline sequencers: state encoding and
// the default event offsets derived from the pipeline stage latencies.
package nfu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COEF = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int STG_NBIN = 1;
    localparam int STG_NFU1 = 3;
    localparam int STG_PIPE = 1;
    localparam int STG_NFU2 = 2;
    localparam int STG_NFU3 = 3;

    // The accumulator seed must meet the first product as it enters NFU-2.
    localparam int DEF_LOAD_OFS    = STG_NBIN + STG_NFU1 + STG_PIPE + STG_NFU2;
    localparam int DEF_WR_OFS_NFU2 = DEF_LOAD_OFS + STG_NFU3;
    localparam int DEF_WR_OFS_NFU3 = DEF_WR_OFS_NFU2 + STG_NFU3;

endpackage

// File: rtl/nfu_tile_timer.sv
// Tile cycle counter with the event comparators, evaluated on the next count value
// so the owning FSM can register the strobes aligned with the counter.
module nfu_tile_timer
    import nfu_ctrl_pkg::*;
#(
    parameter int CNT_W       = 10,
    parameter int LOAD_OFS    = DEF_LOAD_OFS,
    parameter int WR_OFS_NFU2 = DEF_WR_OFS_NFU2,
    parameter int WR_OFS_NFU3 = DEF_WR_OFS_NFU3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_adv,
    input  logic [CNT_W-1:0] i_k,
    input  logic             i_final,
    output logic [CNT_W-1:0] o_t_nx,
    output logic             o_issue_nx,
    output logic             o_nbout_rd_nx,
    output logic             o_load_nx,
    output logic             o_wr_nx
);

    localparam logic [CNT_W-1:0] C_NBRD = CNT_W'(LOAD_OFS - 1);
    localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(LOAD_OFS);
    localparam logic [CNT_W-1:0] C_WR2  = CNT_W'(WR_OFS_NFU2);
    localparam logic [CNT_W-1:0] C_WR3  = CNT_W'(WR_OFS_NFU3);

    logic [CNT_W-1:0] r_t;
    logic [CNT_W-1:0] w_t_nx;
    logic [CNT_W-1:0] w_wr_at;

    always_comb begin
        w_t_nx  = i_clr ? '0 : r_t + CNT_W'(1);
        w_wr_at = i_k - CNT_W'(1) + (i_final ? C_WR3 : C_WR2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t <= '0;
        end else if (i_clr) begin
            r_t <= '0;
        end else if (i_adv) begin
            r_t <= r_t + CNT_W'(1);
        end
    end

    assign o_t_nx        = w_t_nx;
    assign o_issue_nx    = (w_t_nx < i_k);
    assign o_nbout_rd_nx = (w_t_nx == C_NBRD);
    assign o_load_nx     = (w_t_nx == C_LOAD);
    assign o_wr_nx       = (w_t_nx == w_wr_at);

endmodule

// File: rtl/nfu_tile_sequencer.sv
// Control FSM for one NFU output tile: back-to-back NBin/SB reads, NBout seed and
// write-back timing, plus the sigmoid coefficient load path into NFU-3.
module nfu_tile_sequencer
    import nfu_ctrl_pkg::*;
#(
    parameter int CNT_W       = 10,
    parameter int LOAD_OFS    = DEF_LOAD_OFS,
    parameter int WR_OFS_NFU2 = DEF_WR_OFS_NFU2,
    parameter int WR_OFS_NFU3 = DEF_WR_OFS_NFU3,
    parameter int SIG_ENTRIES = 16,
    parameter int COEF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_blocks,
    input  logic              i_final,
    input  logic              i_buf_ready,
    input  logic              i_coef_start,
    input  logic              i_coef_valid,
    input  logic [COEF_W-1:0] i_coef_data,
    output logic              o_coef_ready,
    output logic [COEF_W-1:0] o_sigmoid_coef,
    output logic              o_load_sigmoid_coef,
    output logic              o_rd_en,
    output logic [CNT_W-1:0]  o_rd_idx,
    output logic              o_nbout_rd_en,
    output logic              o_load_nbout,
    output logic              o_nbout_nfu2_nfu3,
    output logic              o_nbout_wr_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int               CC_W   = $clog2(SIG_ENTRIES + 1);
    localparam logic [CC_W-1:0]  C_LAST = CC_W'(SIG_ENTRIES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_k;
    logic              r_final;
    logic [CC_W-1:0]   r_coef_cnt;
    logic              r_coef_ready;
    logic              r_rd_en;
    logic [CNT_W-1:0]  r_rd_idx;
    logic              r_nbout_rd_en;
    logic              r_load_nbout;
    logic              r_sel_nfu2;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_idle;
    logic              w_start_ok;
    logic [CNT_W-1:0]  w_k;
    logic              w_final;
    logic [CNT_W-1:0]  w_t_nx;
    logic              w_issue_nx;
    logic              w_nbrd_nx;
    logic              w_load_nx;
    logic              w_wr_nx;
    logic              w_coef_beat;

    // While idle the timer sees the live request so the t=0 strobes register on the start edge.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_start_ok  = w_idle && i_start && i_buf_ready && (i_num_blocks != '0) && !i_coef_start;
    assign w_k         = w_idle ? i_num_blocks : r_k;
    assign w_final     = w_idle ? i_final : r_final;
    assign w_coef_beat = (r_state == ST_COEF) && i_coef_valid;

    nfu_tile_timer #(
        .CNT_W       (CNT_W),
        .LOAD_OFS    (LOAD_OFS),
        .WR_OFS_NFU2 (WR_OFS_NFU2),
        .WR_OFS_NFU3 (WR_OFS_NFU3)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clr         (w_start_ok),
        .i_adv         (r_state == ST_RUN),
        .i_k           (w_k),
        .i_final       (w_final),
        .o_t_nx        (w_t_nx),
        .o_issue_nx    (w_issue_nx),
        .o_nbout_rd_nx (w_nbrd_nx),
        .o_load_nx     (w_load_nx),
        .o_wr_nx       (w_wr_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_k           <= '0;
            r_final       <= 1'b0;
            r_coef_cnt    <= '0;
            r_coef_ready  <= 1'b0;
            r_rd_en       <= 1'b0;
            r_rd_idx      <= '0;
            r_nbout_rd_en <= 1'b0;
            r_load_nbout  <= 1'b0;
            r_sel_nfu2    <= 1'b1;
            r_wr_en       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_rd_en       <= 1'b0;
            r_rd_idx      <= '0;
            r_nbout_rd_en <= 1'b0;
            r_load_nbout  <= 1'b0;
            r_wr_en       <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_coef_start) begin
                        r_state      <= ST_COEF;
                        r_coef_cnt   <= '0;
                        r_coef_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end else if (i_start && (i_num_blocks == '0)) begin
                        r_err <= 1'b1;
                    end else if (w_start_ok) begin
                        r_state       <= ST_RUN;
                        r_k           <= i_num_blocks;
                        r_final       <= i_final;
                        r_busy        <= 1'b1;
                        r_sel_nfu2    <= !i_final;
                        r_rd_en       <= w_issue_nx;
                        r_rd_idx      <= w_issue_nx ? w_t_nx : '0;
                        r_nbout_rd_en <= w_nbrd_nx;
                        r_load_nbout  <= w_load_nx;
                        r_wr_en       <= w_wr_nx;
                    end
                end
                ST_COEF: begin
                    if (i_coef_valid) begin
                        if (r_coef_cnt == C_LAST) begin
                            r_state      <= ST_IDLE;
                            r_coef_cnt   <= '0;
                            r_coef_ready <= 1'b0;
                            r_busy       <= 1'b0;
                        end else begin
                            r_coef_cnt <= r_coef_cnt + CC_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (r_wr_en) begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_sel_nfu2 <= 1'b1;
                    end else begin
                        r_rd_en       <= w_issue_nx;
                        r_rd_idx      <= w_issue_nx ? w_t_nx : '0;
                        r_nbout_rd_en <= w_nbrd_nx;
                        r_load_nbout  <= w_load_nx;
                        r_wr_en       <= w_wr_nx;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_load_sigmoid_coef = w_coef_beat;
        o_sigmoid_coef      = w_coef_beat ? i_coef_data : '0;
    end

    assign o_coef_ready      = r_coef_ready;
    assign o_rd_en           = r_rd_en;
    assign o_rd_idx          = r_rd_idx;
    assign o_nbout_rd_en     = r_nbout_rd_en;
    assign o_load_nbout      = r_load_nbout;
    assign o_nbout_nfu2_nfu3 = r_sel_nfu2;
    assign o_nbout_wr_en     = r_wr_en;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_err             = r_err;

endmodule

// File: tb/tb_nfu_tile_sequencer.sv
// Directed scoreboard bench for nfu_tile_sequencer: stimulus queues hand-computed
// strobe events with their cycle number, a negedge monitor pops and compares them.
module tb_nfu_tile_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_start = 1'b0;
    logic [9:0]  i_num_blocks = '0;
    logic        i_final = 1'b0;
    logic        i_buf_ready = 1'b0;
    logic        i_coef_start = 1'b0;
    logic        i_coef_valid = 1'b0;
    logic [31:0] i_coef_data = '0;
    logic        o_coef_ready;
    logic [31:0] o_sigmoid_coef;
    logic        o_load_sigmoid_coef;
    logic        o_rd_en;
    logic [9:0]  o_rd_idx;
    logic        o_nbout_rd_en;
    logic        o_load_nbout;
    logic        o_nbout_nfu2_nfu3;
    logic        o_nbout_wr_en;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    nfu_tile_sequencer #(
        .CNT_W       (10),
        .LOAD_OFS    (7),
        .WR_OFS_NFU2 (10),
        .WR_OFS_NFU3 (13),
        .SIG_ENTRIES (16),
        .COEF_W      (32)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_start             (i_start),
        .i_num_blocks        (i_num_blocks),
        .i_final             (i_final),
        .i_buf_ready         (i_buf_ready),
        .i_coef_start        (i_coef_start),
        .i_coef_valid        (i_coef_valid),
        .i_coef_data         (i_coef_data),
        .o_coef_ready        (o_coef_ready),
        .o_sigmoid_coef      (o_sigmoid_coef),
        .o_load_sigmoid_coef (o_load_sigmoid_coef),
        .o_rd_en             (o_rd_en),
        .o_rd_idx            (o_rd_idx),
        .o_nbout_rd_en       (o_nbout_rd_en),
        .o_load_nbout        (o_load_nbout),
        .o_nbout_nfu2_nfu3   (o_nbout_nfu2_nfu3),
        .o_nbout_wr_en       (o_nbout_wr_en),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_err               (o_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic        rd;
        logic [9:0]  idx;
        logic        nbrd;
        logic        ld;
        logic        wr;
        logic        sel;
        logic        done;
        logic        err;
        logic        cl;
        logic [31:0] cd;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic push(input int unsigned c, input logic rd, input logic [9:0] idx,
                        input logic nbrd, input logic ld, input logic wr, input logic sel,
                        input logic done, input logic err, input logic cl, input logic [31:0] cd);
        ev_t e;
        e.cyc = c; e.rd = rd; e.idx = idx; e.nbrd = nbrd; e.ld = ld; e.wr = wr;
        e.sel = sel; e.done = done; e.err = err; e.cl = cl; e.cd = cd;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle showing any strobe must match the next queued event.
    always @(negedge clk) begin
        ev_t a;
        ev_t e;
        logic ok;
        a.cyc = cyc; a.rd = o_rd_en; a.idx = o_rd_idx; a.nbrd = o_nbout_rd_en;
        a.ld = o_load_nbout; a.wr = o_nbout_wr_en; a.sel = o_nbout_nfu2_nfu3;
        a.done = o_done; a.err = o_err; a.cl = o_load_sigmoid_coef; a.cd = o_sigmoid_coef;
        if (a.rd || a.nbrd || a.ld || a.wr || a.done || a.err || a.cl) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: cyc=%0d rd=%b idx=%0d nbrd=%b ld=%b wr=%b done=%b err=%b cl=%b, expected no event",
                         a.cyc, a.rd, a.idx, a.nbrd, a.ld, a.wr, a.done, a.err, a.cl);
            end else begin
                e  = q.pop_front();
                ok = (e.cyc == a.cyc) && (e.rd == a.rd) && (!e.rd || e.idx == a.idx) &&
                     (e.nbrd == a.nbrd) && (e.ld == a.ld) && (e.wr == a.wr) &&
                     (!e.wr || e.sel == a.sel) && (e.done == a.done) && (e.err == a.err) &&
                     (e.cl == a.cl) && (!e.cl || e.cd == a.cd);
                if (!ok) begin
                    fails++;
                    $display("FAIL event: got cyc=%0d rd=%b idx=%0d nbrd=%b ld=%b wr=%b sel=%b done=%b err=%b cl=%b cd=%h; expected cyc=%0d rd=%b idx=%0d nbrd=%b ld=%b wr=%b sel=%b done=%b err=%b cl=%b cd=%h",
                             a.cyc, a.rd, a.idx, a.nbrd, a.ld, a.wr, a.sel, a.done, a.err, a.cl, a.cd,
                             e.cyc, e.rd, e.idx, e.nbrd, e.ld, e.wr, e.sel, e.done, e.err, e.cl, e.cd);
                end
            end
        end
    end

    initial begin
        int unsigned e0;

        #2 rst_n = 1'b0;
        #1;
        chk("reset_rd_en", o_rd_en, 0);
        chk("reset_sel", o_nbout_nfu2_nfu3, 1);
        chk("reset_busy", o_busy, 0);
        chk("reset_coef_ready", o_coef_ready, 0);
        chk("reset_strobes", {o_nbout_rd_en, o_load_nbout, o_nbout_wr_en, o_done, o_err}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // K=4 partial tile
        e0 = cyc + 1;
        i_start = 1; i_num_blocks = 10'd4; i_final = 0; i_buf_ready = 1;
        for (int t = 0; t < 4; t++) push(e0 + t, 1, 10'(t), 0, 0, 0, 0, 0, 0, 0, 0);
        push(e0 + 6,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        push(e0 + 7,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        push(e0 + 13, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        push(e0 + 14, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        i_start = 0;
        chk("k4_busy", o_busy, 1);
        chk("k4_sel_run", o_nbout_nfu2_nfu3, 1);
        repeat (16) tick();
        chk("k4_idle_after", o_busy, 0);

        // K=1 final tile
        e0 = cyc + 1;
        i_start = 1; i_num_blocks = 10'd1; i_final = 1;
        push(e0,      1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(e0 + 6,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        push(e0 + 7,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        push(e0 + 13, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        push(e0 + 14, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        i_start = 0; i_final = 0;
        chk("k1_sel_run", o_nbout_nfu2_nfu3, 0);
        repeat (16) tick();

        // K=0 is an error; start without buffer ready is silently ignored
        e0 = cyc + 1;
        i_start = 1; i_num_blocks = 10'd0;
        push(e0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        i_start = 0;
        chk("k0_busy", o_busy, 0);
        tick();
        chk("k0_busy_later", o_busy, 0);
        i_start = 1; i_num_blocks = 10'd4; i_buf_ready = 0;
        tick();
        i_start = 0; i_buf_ready = 1;
        chk("nobuf_busy", o_busy, 0);
        tick();

        // Coefficient load with toggling valid; a start held during COEF is ignored
        i_coef_start = 1;
        tick();
        i_coef_start = 0;
        chk("coef_ready", o_coef_ready, 1);
        chk("coef_busy", o_busy, 1);
        i_start = 1; i_num_blocks = 10'd4;
        for (int n = 0; n < 32; n++) begin
            i_coef_valid = (n % 2 == 0);
            i_coef_data  = 32'hC0DE_0000 + 32'(n);
            if (n == 31) i_start = 0;
            if (i_coef_valid) push(cyc, 0, 0, 0, 0, 0, 0, 0, 0, 1, i_coef_data);
            tick();
        end
        i_coef_valid = 0;
        chk("coef_ready_dropped", o_coef_ready, 0);
        chk("coef_idle", o_busy, 0);
        i_coef_valid = 1;
        tick();
        i_coef_valid = 0;

        // Simultaneous start and coefficient start: COEF wins, no reads
        i_start = 1; i_num_blocks = 10'd4; i_coef_start = 1;
        tick();
        i_start = 0; i_coef_start = 0;
        chk("both_coef_ready", o_coef_ready, 1);
        chk("both_rd_en", o_rd_en, 0);
        for (int n = 0; n < 16; n++) begin
            i_coef_valid = 1;
            i_coef_data  = 32'hA5A5_0000 + 32'(n * 3);
            push(cyc, 0, 0, 0, 0, 0, 0, 0, 0, 1, i_coef_data);
            tick();
        end
        i_coef_valid = 0;
        tick();
        chk("both_coef_done", o_coef_ready, 0);

        // Reset at t=5 of a K=20 tile
        e0 = cyc + 1;
        i_start = 1; i_num_blocks = 10'd20; i_final = 0;
        for (int t = 0; t < 6; t++) push(e0 + t, 1, 10'(t), 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        i_start = 0;
        for (int w = 0; w < 10 && cyc < e0 + 5; w++) tick();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_rd_en", o_rd_en, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_sel", o_nbout_nfu2_nfu3, 1);
        chk("abort_strobes", {o_nbout_rd_en, o_load_nbout, o_nbout_wr_en, o_done, o_err}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // K=8 tile: reads coincide with the NBout read and load events
        e0 = cyc + 1;
        i_start = 1; i_num_blocks = 10'd8; i_final = 0;
        for (int t = 0; t < 6; t++) push(e0 + t, 1, 10'(t), 0, 0, 0, 0, 0, 0, 0, 0);
        push(e0 + 6,  1, 10'd6, 1, 0, 0, 0, 0, 0, 0, 0);
        push(e0 + 7,  1, 10'd7, 0, 1, 0, 0, 0, 0, 0, 0);
        push(e0 + 17, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        push(e0 + 18, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        i_start = 0;
        chk("k8_busy", o_busy, 1);
        repeat (20) tick();
        chk("k8_idle", o_busy, 0);

        repeat (3) tick();
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
